rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4.sv | 93 +++++++++
 tb/tb_rr_arbiter_4.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time per owner.
// Grants are registered; every release returns through one IDLE cycle.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout,
  output logic       dbg_state
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_gnt_id;
  logic [3:0] r_gnt;
  logic [7:0] r_cnt;
  logic       r_timeout;

  logic       w_any;
  logic [1:0] w_win;
  logic [1:0] w_idx;
  logic       w_owner_req;
  logic       w_hold_max;

  function automatic logic [3:0] decode_id(input logic [1:0] id);
    decode_id = 4'b0001 << id;
  endfunction

  // Scan offsets from highest to lowest so the nearest requester above ptr wins.
  always_comb begin
    w_any = |req;
    w_win = r_ptr;
    w_idx = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) w_win = w_idx;
    end
  end

  assign w_owner_req = req[r_gnt_id];
  assign w_hold_max  = (r_cnt == 8'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_gnt_id  <= 2'd0;
      r_gnt     <= 4'b0000;
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_GRANT;
            r_gnt_id <= w_win;
            r_gnt    <= decode_id(w_win);
            r_cnt    <= 8'd1;
          end
        end
        S_GRANT: begin
          // Counter stops at MAX_HOLD, so it can never wrap within 1..255.
          if (!w_owner_req || w_hold_max) begin
            r_state   <= S_IDLE;
            r_gnt     <= 4'b0000;
            r_ptr     <= r_gnt_id + 2'd1;
            r_cnt     <= 8'd0;
            r_timeout <= w_owner_req;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign busy      = (r_state == S_GRANT);
  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Randomized bench for rr_arbiter_4 against an owner/pointer reference model,
// with directed priority, wrap, timeout and asynchronous-reset scenarios.
module tb_rr_arbiter_4;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;
  logic       dbg_state;

  int n_vec;
  int n_err;

  // Reference model: owner index (-1 = none), cycles held, next search start.
  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_to;
  bit prev_to;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_to    = 0;
    prev_to = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    bit found;
    int idx;
    if (m_owner < 0) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!found && r[idx]) begin
          found   = 1;
          m_owner = idx;
          m_hold  = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_to    = 0;
    end else if (m_hold == MH) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_to    = 1;
    end else begin
      m_hold++;
      m_to = 0;
    end
  endtask

  // Scoreboard compare plus the always-on invariants.
  task automatic compare_all();
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check_eq("gnt", 8'(gnt), 8'(exp_gnt));
    check_eq("busy", 8'(busy), 8'(m_owner >= 0));
    check_eq("timeout", 8'(timeout), 8'(m_to));
    if (m_owner >= 0) check_eq("gnt_id", 8'(gnt_id), 8'(m_owner));
    check_eq("onehot0", 8'($onehot0(gnt)), 8'd1);
    if (busy) check_eq("decode", 8'(gnt), 8'(4'b0001 << gnt_id));
    check_eq("to_twice", 8'(prev_to & timeout), 8'd0);
    prev_to = timeout;
  endtask

  // Driver: called in the low phase; applies req for one rising edge.
  task automatic drive_cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges and checks that outputs drop with no clock.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_gnt", 8'(gnt), 8'd0);
    check_eq("arst_busy", 8'(busy), 8'd0);
    check_eq("arst_to", 8'(timeout), 8'd0);
    check_eq("arst_id", 8'(gnt_id), 8'd0);
    @(posedge clk);
    @(negedge clk);
    check_eq("arst_hold", 8'(gnt), 8'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    n_vec = 0;
    n_err = 0;
    req   = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_gnt", 8'(gnt), 8'd0);
    check_eq("rst_busy", 8'(busy), 8'd0);
    check_eq("rst_to", 8'(timeout), 8'd0);
    check_eq("rst_id", 8'(gnt_id), 8'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Priority after reset, then hand-over to requester 1 after a bubble.
    drive_cycle(4'b1111);
    check_eq("prio_first", 8'(gnt), 8'b0001);
    drive_cycle(4'b1110);
    check_eq("prio_bubble", 8'(gnt), 8'b0000);
    drive_cycle(4'b1110);
    check_eq("prio_next", 8'(gnt), 8'b0010);

    // Drive ptr to 3, then 0101 must wrap to requester 0.
    drive_cycle(4'b0000);
    drive_cycle(4'b0101);
    check_eq("wrap_pre", 8'(gnt), 8'b0100);
    drive_cycle(4'b0001);
    drive_cycle(4'b0101);
    check_eq("wrap_skip", 8'(gnt), 8'b0001);

    // Held request is cut after MH cycles, with a timeout bubble, then regranted.
    drive_cycle(4'b0000);
    drive_cycle(4'b0100);
    for (int i = 1; i < MH; i++) drive_cycle(4'b0100);
    check_eq("to_last_hold", 8'(gnt), 8'b0100);
    drive_cycle(4'b0100);
    check_eq("to_gnt", 8'(gnt), 8'b0000);
    check_eq("to_pulse", 8'(timeout), 8'd1);
    drive_cycle(4'b0100);
    check_eq("to_regrant", 8'(gnt), 8'b0100);
    check_eq("to_clear", 8'(timeout), 8'd0);
    drive_cycle(4'b0000);

    // Rotation: everyone requests, owner drops after two cycles.
    for (int g = 0; g < 5; g++) begin
      r = 4'b1111;
      drive_cycle(r);
      drive_cycle(r);
      if (m_owner >= 0) r[m_owner] = 1'b0;
      drive_cycle(r);
    end

    // Reset mid-grant of requester 3; first edge after release regrants it.
    async_reset();
    drive_cycle(4'b1000);
    check_eq("rst_mid_pre", 8'(gnt), 8'b1000);
    drive_cycle(4'b1000);
    async_reset();
    drive_cycle(4'b1000);
    check_eq("rst_mid_post", 8'(gnt), 8'b1000);

    // Random traffic with sticky request patterns so holds reach MH.
    r = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) async_reset();
      drive_cycle(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
